// File: rtl/lv_owt_tx.sv
// One-wire frame transmitter for the LV->HV isolation channel.
// Sends head, cmd/data/CRC8 as pulse-width encoded bits, then a mandatory idle gap.
`timescale 1ns/1ps
module lv_owt_tx #(
  parameter int BIT_CYC  = 16,
  parameter int HEAD_HI  = 2,
  parameter int HEAD_LO  = 1,
  parameter int GAP_BITS = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tx_en,
  input  logic       i_tx_vld,
  output logic       o_tx_rdy,
  input  logic [7:0] i_tx_cmd,
  input  logic [7:0] i_tx_data,
  output logic       o_lv_hv_owt_tx,
  output logic       o_tx_busy,
  output logic       o_tx_done
);

  localparam int HEAD_HI_CYC = HEAD_HI * BIT_CYC;
  localparam int HEAD_CYC    = (HEAD_HI + HEAD_LO) * BIT_CYC;
  localparam int GAP_CYC     = GAP_BITS * BIT_CYC;
  localparam int ONE_HI_CYC  = 3 * BIT_CYC / 4;
  localparam int ZERO_HI_CYC = BIT_CYC / 4;
  localparam int MAX_HB      = (HEAD_CYC > BIT_CYC) ? HEAD_CYC : BIT_CYC;
  localparam int MAX_PHASE   = (MAX_HB > GAP_CYC) ? MAX_HB : GAP_CYC;
  localparam int CW          = $clog2(MAX_PHASE);

  localparam logic [CW:0] HEAD_END    = HEAD_CYC[CW:0];
  localparam logic [CW:0] HEAD_HI_END = HEAD_HI_CYC[CW:0];
  localparam logic [CW:0] BIT_END     = BIT_CYC[CW:0];
  localparam logic [CW:0] GAP_END     = GAP_CYC[CW:0];
  localparam logic [CW:0] ONE_HI      = ONE_HI_CYC[CW:0];
  localparam logic [CW:0] ZERO_HI     = ZERO_HI_CYC[CW:0];

  typedef enum logic [1:0] {IDLE, HEAD, BITS, GAP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [4:0]    bit_cnt;
  logic [23:0]   sreg;
  logic [CW:0]   cnt_inc;
  logic [CW:0]   bit_hi;

  // CRC8, poly 0x07, init 0xFF, MSB-first over cmd then data
  function automatic logic [7:0] crc8(input logic [15:0] bytes);
    logic [7:0] c;
    c = 8'hFF;
    for (int i = 15; i >= 0; i--) begin
      c = {c[6:0], 1'b0} ^ ((c[7] ^ bytes[i]) ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  assign o_tx_rdy = (state == IDLE) && i_tx_en && !i_rst;
  assign cnt_inc  = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};
  assign bit_hi   = sreg[23] ? ONE_HI : ZERO_HI;

  // The line is registered: each branch loads the level for the coming cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= IDLE;
      cnt            <= '0;
      bit_cnt        <= '0;
      sreg           <= '0;
      o_lv_hv_owt_tx <= 1'b0;
      o_tx_busy      <= 1'b0;
      o_tx_done      <= 1'b0;
    end else begin
      o_tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_tx_vld && o_tx_rdy) begin
            state          <= HEAD;
            cnt            <= '0;
            sreg           <= {i_tx_cmd, i_tx_data, crc8({i_tx_cmd, i_tx_data})};
            o_lv_hv_owt_tx <= 1'b1;
            o_tx_busy      <= 1'b1;
          end
        end
        HEAD: begin
          if (cnt_inc == HEAD_END) begin
            state          <= BITS;
            cnt            <= '0;
            bit_cnt        <= '0;
            o_lv_hv_owt_tx <= 1'b1;
          end else begin
            cnt            <= cnt_inc[CW-1:0];
            o_lv_hv_owt_tx <= (cnt_inc < HEAD_HI_END);
          end
        end
        BITS: begin
          if (cnt_inc == BIT_END) begin
            cnt <= '0;
            if (bit_cnt == 5'd23) begin
              state          <= GAP;
              o_lv_hv_owt_tx <= 1'b0;
              o_tx_done      <= 1'b1;
            end else begin
              bit_cnt        <= bit_cnt + 5'd1;
              sreg           <= {sreg[22:0], 1'b0};
              o_lv_hv_owt_tx <= 1'b1;
            end
          end else begin
            cnt            <= cnt_inc[CW-1:0];
            o_lv_hv_owt_tx <= (cnt_inc < bit_hi);
          end
        end
        GAP: begin
          if (cnt_inc == GAP_END) begin
            state     <= IDLE;
            cnt       <= '0;
            o_tx_busy <= 1'b0;
          end else begin
            cnt <= cnt_inc[CW-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lv_owt_tx.sv
// Bench for lv_owt_tx: a line decoder rebuilds frames and a scoreboard compares them,
// plus done/busy timing, against hand-computed expectations queued at accept time.
`timescale 1ns/1ps
module tb_lv_owt_tx;

  logic       clk = 1'b0;
  logic       rst, en, vld;
  logic       rdy;
  logic [7:0] cmd, data;
  logic       line, busy, done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [23:0] word;
    int          start;
  } frame_t;

  frame_t frame_q[$];
  int     done_q[$];
  int     busy_q[$];

  lv_owt_tx dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_tx_en        (en),
    .i_tx_vld       (vld),
    .o_tx_rdy       (rdy),
    .i_tx_cmd       (cmd),
    .i_tx_data      (data),
    .o_lv_hv_owt_tx (line),
    .o_tx_busy      (busy),
    .o_tx_done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: decodes run lengths on the line, checks done/busy timing
  logic        prev_line = 1'b0;
  logic        prev_busy = 1'b0;
  int          run = 0, dstate = 0, nb = 0, hlen = 0, fmt_err = 0, start = 0;
  logic [23:0] word = '0;

  initial begin
    frame_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        dstate = 0; run = 0; fmt_err = 0;
        prev_line = line; prev_busy = busy;
        continue;
      end
      if (done) begin
        if (done_q.size() == 0) check_output("unexpected_done", 1, 0);
        else check_output("done_cycle", cyc, done_q.pop_front());
      end
      if (prev_busy && !busy) begin
        if (busy_q.size() == 0) check_output("unexpected_busy_end", 1, 0);
        else check_output("busy_end_cycle", cyc, busy_q.pop_front());
      end
      prev_busy = busy;
      if (line != prev_line) begin
        if (prev_line) begin
          case (dstate)
            0: begin
              if (run != 32) fmt_err++;
              dstate = 1;
            end
            2: begin
              if (run != 4 && run != 12) fmt_err++;
              word = {word[22:0], (run == 12)};
              nb++;
              if (nb == 24) begin
                dstate = 0;
                if (frame_q.size() == 0) check_output("unexpected_frame", 1, 0);
                else begin
                  e = frame_q.pop_front();
                  check_output("frame_word", int'(word), int'(e.word));
                  check_output("frame_start", start, e.start);
                  check_output("frame_format_errors", fmt_err, 0);
                end
              end else begin
                hlen   = run;
                dstate = 3;
              end
            end
            default: fmt_err++;
          endcase
        end else begin
          case (dstate)
            0: begin
              start   = cyc;
              fmt_err = 0;
            end
            1: begin
              if (run != 16) fmt_err++;
              dstate = 2; nb = 0; word = '0;
            end
            3: begin
              if (hlen + run != 16) fmt_err++;
              dstate = 2;
            end
            default: ;
          endcase
        end
        run = 1;
      end else begin
        run++;
      end
      prev_line = line;
    end
  end

  // Called at a negedge with vld driven; returns just after the accepting edge's preceding negedge
  task automatic wait_accept(output int s, output logic ok);
    ok = 1'b0;
    s  = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      #1;
      if (rdy && vld) begin
        s  = cyc + 1;
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) check_output("accept_timeout", 0, 1);
  endtask

  task automatic expect_frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] crc,
                              input int s);
    frame_t f;
    f.word  = {c, d, crc};
    f.start = s;
    frame_q.push_back(f);
    done_q.push_back(s + 432);
    busy_q.push_back(s + 464);
  endtask

  task automatic apply_stimulus(input logic [7:0] c, input logic [7:0] d, input logic [7:0] crc);
    int   s;
    logic ok;
    @(negedge clk);
    vld = 1'b1; cmd = c; data = d;
    wait_accept(s, ok);
    if (ok) expect_frame(c, d, crc, s);
    @(negedge clk);
    vld = 1'b0; cmd = 8'hFF; data = 8'hFF;
  endtask

  task automatic wait_idle();
    int pending;
    pending = 1;
    for (int i = 0; i < 3000 && pending != 0; i++) begin
      @(negedge clk);
      pending = int'(busy) + frame_q.size() + done_q.size() + busy_q.size();
    end
    check_output("drain_pending", pending, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   s, prev_s, viol;
    logic ok;
    rst = 1'b1; en = 1'b1; vld = 1'b1; cmd = 8'h00; data = 8'h00;
    repeat (3) @(negedge clk);
    check_output("reset_line", int'(line), 0);
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_done", int'(done), 0);
    check_output("reset_rdy", int'(rdy), 0);
    rst = 1'b0; vld = 1'b0;
    @(negedge clk);
    check_output("no_accept_during_reset", int'(busy), 0);

    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (line || busy || !rdy || done) viol++;
    end
    check_output("idle_100_cycles", viol, 0);

    apply_stimulus(8'h00, 8'h00, 8'hD7);
    wait_idle();
    apply_stimulus(8'hA5, 8'h3C, 8'h3A);
    wait_idle();

    $display("[TB] back-to-back frames with vld held");
    @(negedge clk);
    vld = 1'b1; cmd = 8'hA5; data = 8'h3C;
    prev_s = 0;
    for (int k = 0; k < 3; k++) begin
      wait_accept(s, ok);
      if (ok) expect_frame(8'hA5, 8'h3C, 8'h3A, s);
      if (k > 0) check_output("back_to_back_spacing", s - prev_s, 465);
      prev_s = s;
      @(negedge clk);
    end
    vld = 1'b0;
    wait_idle();

    $display("[TB] reset mid-frame");
    @(negedge clk);
    vld = 1'b1; cmd = 8'h5A; data = 8'h77;
    wait_accept(s, ok);
    @(negedge clk);
    vld = 1'b0;
    repeat (199) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("midreset_line", int'(line), 0);
    check_output("midreset_busy", int'(busy), 0);
    check_output("midreset_done", int'(done), 0);
    check_output("midreset_rdy_in_reset", int'(rdy), 0);
    rst = 1'b0;
    @(negedge clk);
    check_output("rdy_after_reset", int'(rdy), 1);
    apply_stimulus(8'h00, 8'h00, 8'hD7);
    wait_idle();

    $display("[TB] enable gating");
    en = 1'b0; vld = 1'b1; cmd = 8'hA5; data = 8'h3C;
    viol = 0;
    repeat (50) begin
      @(negedge clk);
      if (rdy || line || busy) viol++;
    end
    check_output("en_low_no_accept", viol, 0);
    en = 1'b1;
    wait_accept(s, ok);
    if (ok) expect_frame(8'hA5, 8'h3C, 8'h3A, s);
    @(negedge clk);
    repeat (99) @(negedge clk);
    en = 1'b0;
    viol = 0;
    repeat (520) begin
      @(negedge clk);
      if (rdy) viol++;
    end
    check_output("no_accept_after_en_drop", viol, 0);
    check_output("idle_after_en_drop", int'(busy), 0);
    vld = 1'b0;
    wait_idle();

    repeat (10) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
